// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: fetch/decode/execute/memory/write-back sequencing,
// memory wait-state stretching, multi-cycle MUL hold and a sticky illegal-instruction trap.
module multicycle_control #(
    parameter int unsigned INSTR_W     = 32,
    parameter int unsigned MUL_LATENCY = 4,
    parameter logic [5:0]  OP_LW       = 6'b001000,
    parameter logic [5:0]  OP_SW       = 6'b001001,
    parameter logic [5:0]  OP_RTYPE    = 6'b000111,
    parameter logic [5:0]  FN_ADD      = 6'b100000,
    parameter logic [5:0]  FN_SUB      = 6'b100010,
    parameter logic [5:0]  FN_AND      = 6'b100100,
    parameter logic [5:0]  FN_OR       = 6'b100101,
    parameter logic [5:0]  FN_MUL      = 6'b110010
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instructionIn,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               ir_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               alu_src_b,
    output logic [2:0]         alu_op,
    output logic               mul_start,
    output logic               illegal,
    output logic [2:0]         state
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StMulw   = 3'd5,
        StTrap   = 3'd6
    } state_e;

    localparam int unsigned CntW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(MUL_LATENCY - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [5:0]      op_q, op_d;
    logic [5:0]      fn_q, fn_d;
    logic            illegal_q, illegal_d;

    logic [5:0] opcode;
    logic [5:0] funct;
    assign opcode = instructionIn[INSTR_W-1 -: 6];
    assign funct  = instructionIn[5:0];

    // Middle instruction bits (register fields, immediate) are datapath-only.
    logic unused_instr;
    assign unused_instr = ^instructionIn[INSTR_W-7:6];

    function automatic logic is_alu_fn(input logic [5:0] fn);
        return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) || (fn == FN_OR);
    endfunction

    function automatic logic [2:0] alu_code(input logic [5:0] fn);
        logic [2:0] code;
        code = 3'b000;
        if (fn == FN_SUB) code = 3'b001;
        if (fn == FN_AND) code = 3'b010;
        if (fn == FN_OR)  code = 3'b011;
        return code;
    endfunction

    // Next-state, MUL counter, decode register and trap flag.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        fn_d      = fn_q;
        illegal_d = illegal_q;
        case (state_q)
            StFetch: begin
                if (mem_ready) state_d = StDecode;
            end
            StDecode: begin
                op_d = opcode;
                fn_d = funct;
                if (opcode == OP_LW || opcode == OP_SW) begin
                    state_d = StExec;
                end else if (opcode == OP_RTYPE && is_alu_fn(funct)) begin
                    state_d = StExec;
                end else if (opcode == OP_RTYPE && funct == FN_MUL) begin
                    state_d = StMulw;
                    cnt_d   = '0;
                end else begin
                    state_d   = StTrap;
                    illegal_d = 1'b1;
                end
            end
            StExec: begin
                state_d = (op_q == OP_LW || op_q == OP_SW) ? StMem : StWb;
            end
            StMulw: begin
                if (cnt_q == CntLast) state_d = StWb;
                else                  cnt_d   = cnt_q + 1'b1;
            end
            StMem: begin
                if (mem_ready) state_d = (op_q == OP_SW) ? StFetch : StWb;
            end
            StWb:    state_d = StFetch;
            StTrap:  state_d = StTrap;
            default: state_d = StFetch;
        endcase
    end

    // State and control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StFetch;
            cnt_q     <= '0;
            op_q      <= '0;
            fn_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            fn_q      <= fn_d;
            illegal_q <= illegal_d;
        end
    end

    // Datapath strobes; all forced low while reset is held.
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_b  = 1'b0;
        alu_op     = 3'b000;
        mul_start  = 1'b0;
        illegal    = 1'b0;
        state      = 3'd0;
        if (!rst) begin
            state   = state_q;
            illegal = illegal_q;
            case (state_q)
                StFetch: begin
                    mem_read = 1'b1;
                    // IR/PC load is Mealy so it lands in the cycle memory completes.
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                StExec: begin
                    if (op_q == OP_LW || op_q == OP_SW) alu_src_b = 1'b1;
                    else                                alu_op    = alu_code(fn_q);
                end
                StMulw: begin
                    alu_op    = 3'b100;
                    mul_start = (cnt_q == '0);
                end
                StMem: begin
                    mem_read  = (op_q == OP_LW);
                    mem_write = (op_q == OP_SW);
                end
                StWb: begin
                    reg_write  = 1'b1;
                    reg_dst    = (op_q == OP_RTYPE);
                    mem_to_reg = (op_q == OP_LW);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: directed vector table, hand-built corner sequences and random
// instruction streams checked against a per-instruction cycle-trace model.
module tb_multicycle_control;

    localparam int unsigned MulLat = 4;
    localparam logic [5:0] OpLw = 6'b001000, OpSw = 6'b001001, OpRt = 6'b000111;
    localparam logic [5:0] FnAdd = 6'b100000, FnSub = 6'b100010, FnAnd = 6'b100100;
    localparam logic [5:0] FnOr = 6'b100101, FnMul = 6'b110010;

    // Expected-output bit layout: [15:13] state, then strobes, [4:2] alu_op.
    localparam logic [15:0] EPcw = 16'h1000, EIrw = 16'h0800, EMr = 16'h0400;
    localparam logic [15:0] EMw = 16'h0200, ERw = 16'h0100, ERd = 16'h0080;
    localparam logic [15:0] EM2r = 16'h0040, EAsb = 16'h0020, EMs = 16'h0002;
    localparam logic [15:0] EIll = 16'h0001;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instructionIn;
    logic        mem_ready;
    logic        pc_write, ir_write, mem_read, mem_write, reg_write, reg_dst;
    logic        mem_to_reg, alu_src_b, mul_start, illegal;
    logic [2:0]  alu_op, state;
    logic [15:0] act;

    multicycle_control #(.INSTR_W(32), .MUL_LATENCY(MulLat)) dut (
        .clk(clk), .rst(rst), .instructionIn(instructionIn), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .mul_start(mul_start), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    assign act = {state, pc_write, ir_write, mem_read, mem_write, reg_write, reg_dst,
                  mem_to_reg, alu_src_b, alu_op, mul_start, illegal};

    typedef struct packed {
        logic        rst;
        logic [31:0] instr;
        logic        ready;
        logic [15:0] exp;
    } vec_t;

    vec_t q[$];
    vec_t tbl[6];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [15:0] st(input int n);
        return 16'(n) << 13;
    endfunction

    function automatic vec_t rec(input logic r, input logic [31:0] ins, input logic rdy,
                                 input logic [15:0] e);
        vec_t v;
        v.rst = r; v.instr = ins; v.ready = rdy; v.exp = e;
        return v;
    endfunction

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [5:0] fn);
        return {op, 20'($urandom), fn};
    endfunction

    task automatic apply(input vec_t v, input string name);
        rst = v.rst; instructionIn = v.instr; mem_ready = v.ready;
        @(negedge clk);
        checks++;
        if (act !== v.exp) begin
            errors++;
            $display("FAIL %s check %0d: outputs got %h expected %h", name, checks, act, v.exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input string name);
        while (q.size() > 0) apply(q.pop_front(), name);
    endtask

    // Expand one instruction into its expected cycle-by-cycle trace, starting in FETCH.
    // wf/wm: memory wait cycles in fetch / memory access.
    task automatic gen(input logic [31:0] ins, input int wf, input int wm);
        logic [5:0] op, fn;
        logic [5:0] alu_fns[4];
        int code;
        op = ins[31:26];
        fn = ins[5:0];
        alu_fns = '{FnAdd, FnSub, FnAnd, FnOr};
        code = -1;
        for (int i = 0; i < 4; i++) if (fn == alu_fns[i]) code = i;
        for (int i = 0; i < wf; i++) q.push_back(rec(0, $urandom, 0, st(0) | EMr));
        q.push_back(rec(0, $urandom, 1, st(0) | EMr | EIrw | EPcw));
        q.push_back(rec(0, ins, 1'($urandom), st(1)));
        if (op == OpLw || op == OpSw) begin
            q.push_back(rec(0, $urandom, 1'($urandom), st(2) | EAsb));
            for (int i = 0; i <= wm; i++)
                q.push_back(rec(0, $urandom, (i == wm), st(3) | ((op == OpLw) ? EMr : EMw)));
            if (op == OpLw) q.push_back(rec(0, $urandom, 1'($urandom), st(4) | ERw | EM2r));
        end else if (op == OpRt && code >= 0) begin
            q.push_back(rec(0, $urandom, 1'($urandom), st(2) | (16'(code) << 2)));
            q.push_back(rec(0, $urandom, 1'($urandom), st(4) | ERw | ERd));
        end else if (op == OpRt && fn == FnMul) begin
            for (int i = 0; i < int'(MulLat); i++)
                q.push_back(rec(0, $urandom, 1'($urandom),
                                st(5) | (16'd4 << 2) | ((i == 0) ? EMs : 16'h0)));
            q.push_back(rec(0, $urandom, 1'($urandom), st(4) | ERw | ERd));
        end else begin
            for (int i = 0; i < 12; i++) q.push_back(rec(0, $urandom, 1'($urandom), st(6) | EIll));
            q.push_back(rec(1, $urandom, 1'($urandom), 16'h0));
        end
    endtask

    initial begin
        logic [31:0] add_i;
        logic [5:0]  fns[5];
        rst = 1'b1; instructionIn = '0; mem_ready = 1'b0;
        @(posedge clk);
        #1;

        // Directed ADD: reset, fetch, decode, exec, wb, stalled fetch.
        add_i  = 32'h1C2A_5020;
        tbl[0] = rec(1, add_i, 1, 16'h0);
        tbl[1] = rec(0, 32'h0, 1, st(0) | EMr | EIrw | EPcw);
        tbl[2] = rec(0, add_i, 0, st(1));
        tbl[3] = rec(0, 32'hFFFF_FFFF, 0, st(2));
        tbl[4] = rec(0, 32'hFFFF_FFFF, 0, st(4) | ERw | ERd);
        tbl[5] = rec(0, 32'h0, 0, st(0) | EMr);
        for (int i = 0; i < 6; i++) apply(tbl[i], "add_table");

        gen(mk(OpLw, 6'h15), 0, 2);            run("lw_mem_wait");
        gen(mk(OpSw, 6'h2A), 1, 0);            run("sw_fetch_wait");
        gen(mk(OpRt, FnMul), 0, 0);            run("mul");
        gen(mk(6'b111111, FnAdd), 0, 0);       run("trap_opcode");
        gen(mk(OpRt, 6'b000000), 0, 0);        run("trap_funct");

        // Reset on the second MULW cycle, then a clean ADD.
        gen(mk(OpRt, FnMul), 0, 0);
        while (q.size() > 3) void'(q.pop_back());
        q.push_back(rec(1, $urandom, 1, 16'h0));
        gen(mk(OpRt, FnAdd), 0, 0);
        run("mul_reset");

        fns = '{FnAdd, FnSub, FnAnd, FnOr, FnMul};
        for (int n = 0; n < 150; n++) begin
            int k;
            logic [31:0] ins;
            k = $urandom_range(0, 8);
            if (k == 0)      ins = mk(OpLw, 6'($urandom));
            else if (k == 1) ins = mk(OpSw, 6'($urandom));
            else if (k <= 6) ins = mk(OpRt, fns[k-2]);
            else if (k == 7) ins = mk(OpRt, 6'($urandom));
            else             ins = $urandom;
            gen(ins, $urandom_range(0, 2), $urandom_range(0, 2));
            run("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle, parametrised successor to the combinational control decoder of the MIPS datapath. The FSM sequences each instruction through fetch, decode, execute, memory and write-back. It stretches fetch and memory states on memory wait-states and holds MUL for a configurable number of cycles. It drives every datapath strobe, and it flags undefined opcodes or function codes with a sticky trap.

## Interface
- INSTR_W, 32: instruction width, ≥32; opcode = instructionIn[INSTR_W-1 -: 6], funct = instructionIn[5:0]
- MUL_LATENCY, 4: MUL execute cycles, ≥1
- OP_LW, 6'b001000; OP_SW, 6'b001001; OP_RTYPE, 6'b000111: opcodes
- FN_ADD, 6'b100000; FN_SUB, 6'b100010; FN_AND, 6'b100100; FN_OR, 6'b100101; FN_MUL, 6'b110010: R-type functs
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- instructionIn  input  INSTR_W  instruction register contents
- mem_ready  input  1  memory completes the access this cycle
- pc_write, ir_write  output  1  PC / IR load strobes
- mem_read, mem_write  output  1  memory strobes
- reg_write  output  1  register file write
- reg_dst  output  1  1 = rd, 0 = rt
- mem_to_reg  output  1  1 = memory data to register file
- alu_src_b  output  1  1 = sign-extended immediate, 0 = register
- alu_op  output  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 MUL
- mul_start  output  1  one-cycle multiplier launch
- illegal  output  1  sticky trap flag
- state  output  3  FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, MULW 5, TRAP 6

## Operation
- rst=1 at an edge: state←FETCH, MUL counter←0, decode register←0, illegal←0. While rst=1, all outputs are forced to 0. Reset overrides any state, including MULW, MEM and TRAP.
- FETCH: mem_read=1. When mem_ready=1, ir_write and pc_write are asserted in the same cycle (Mealy) and the next state is DECODE. Otherwise the FSM stays in FETCH.
- DECODE: lasts one cycle and latches opcode/funct into the internal decode register. Transitions:
  - LW, SW, or R-type with ADD/SUB/AND/OR → EXEC.
  - R-type MUL → MULW.
  - Any other opcode or funct → TRAP.
- EXEC: lasts one cycle.
  - LW/SW: alu_src_b=1, alu_op=ADD, next state MEM.
  - R-type: alu_src_b=0, alu_op from funct, next state WB.
- MULW: alu_op=100 throughout. mul_start=1 on the first cycle only. The counter is cleared on entry and counts MUL_LATENCY cycles, then the FSM goes to WB.
- MEM: LW drives mem_read=1; SW drives mem_write=1. The FSM holds until mem_ready=1. Then SW → FETCH and LW → WB.
- WB: reg_write=1 for one cycle. reg_dst=1 for R-type (including MUL). mem_to_reg=1 for LW. Next state FETCH.
- TRAP: illegal=1 and all other strobes 0. Held until reset.
- Outputs not named for a state are 0. alu_op defaults to 000.

## Timing
- Latency with mem_ready tied to 1, counted from FETCH entry to return to FETCH:
  - ADD/SUB/AND/OR: 4 cycles.
  - SW: 4 cycles.
  - LW: 5 cycles.
  - MUL: 3+MUL_LATENCY cycles.
- Each cycle of mem_ready=0 in FETCH or MEM adds exactly one cycle. mem_ready is ignored in every other state.
- instructionIn is sampled only in DECODE. Changes in any other state have no effect.
- All strobes except ir_write/pc_write are Moore functions of state plus the decode register.
- MULW with MUL_LATENCY=1: mul_start=1 in the single MULW cycle, next state WB.
- Reset during MULW: the counter is cleared and no WB occurs.

## Test plan
- ADD (0x1C2A_5020-style, opcode 000111, funct 100000), mem_ready=1 → state sequence 0,1,2,4,0. alu_op=000 in EXEC. reg_write=1 and reg_dst=1 in WB only.
- LW (opcode 001000), mem_ready low for 2 cycles in MEM → MEM lasts 3 cycles with mem_read=1. WB has mem_to_reg=1, reg_dst=0. Total 7 cycles.
- SW (opcode 001001), FETCH mem_ready delayed 1 cycle → ir_write asserted once, on the second FETCH cycle. mem_write=1 in MEM. No WB state. Total 5 cycles.
- MUL (funct 110010), MUL_LATENCY=4 → mul_start high exactly 1 cycle, MULW lasts 4 cycles, then WB with reg_write=1. Total 7 cycles.
- Opcode 111111, or R-type funct 000000 → TRAP after DECODE. illegal=1 sticky and other strobes 0 for 10+ cycles. rst=1 clears to FETCH.
- rst asserted on the second MULW cycle → next state FETCH, illegal=0, no reg_write. The following ADD completes normally in 4 cycles.
